adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one WIDTH-bit ripple-carry adder between two requesters.
//  Sequences each transaction through a 3-state FSM and returns a tagged registered result.
//  Sits between operand producers (req0/req1) and a single result consumer.
//  Carry-in is fixed at 0.
// PARAMETERS
//  WIDTH  5  operand and sum width in bits (adder width)
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst_n       in   1      reset; asynchronous, active-low
//  req0_valid  in   1      requester 0 presents operands
//  req0_ready  out  1      requester 0 operands accepted this cycle
//  req0_x      in   WIDTH  requester 0 operand X
//  req0_y      in   WIDTH  requester 0 operand Y
//  req1_valid  in   1      requester 1 presents operands
//  req1_ready  out  1      requester 1 operands accepted this cycle
//  req1_x      in   WIDTH  requester 1 operand X
//  req1_y      in   WIDTH  requester 1 operand Y
//  res_valid   out  1      result available
//  res_ready   in   1      consumer takes result
//  res_id      out  1      requester that owns the result (0/1)
//  res_sum     out  WIDTH  sum
//  res_cout    out  1      carry out of MSB
//  busy        out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, rr_ptr=0.
//   - res_valid=0, res_id=0, res_sum=0, res_cout=0, busy=0, both readys=0.
//   - Any in-flight transaction is discarded without a response.
//  States:
//   - IDLE: grant = rr_ptr side if valid, else other side if valid.
//     Granted reqN_ready=1 combinationally; ungranted ready=0.
//     On valid&ready: latch x,y,id; rr_ptr <= ~id; go to ADD.
//   - ADD: adder evaluates latched operands.
//     {res_cout,res_sum} <= x+y (WIDTH+1 bits); go to RESP.
//   - RESP: res_valid=1; id/sum/cout held stable until res_ready=1, then go to IDLE.
//  Timing:
//   - Latency: accept in cycle N -> res_valid in cycle N+2.
//   - Throughput: at most 1 transaction per 3 cycles; no accept in the cycle of the result handshake.
//   - Both readys=0 in ADD and RESP; requesters hold valid/operands until ready.
//  Arbitration:
//   - Round-robin: after serving id k, the other requester wins the next tie.
//   - A lone requester is served back-to-back regardless of rr_ptr.
//  Arithmetic:
//   - Unsigned, cin=0.
//   - Max case 31+31 = sum 30, cout 1 (WIDTH=5).
// CONFIGURATION
//  ADDER_ARB_SAT_EN defined:
//   - When cout=1, res_sum is forced to all ones (31 for WIDTH=5); res_cout still reports 1.
//  ADDER_ARB_SAT_EN undefined:
//   - res_sum wraps modulo 2^WIDTH.
// STRUCTURE
//  Header adder_arb_defs.vh, shared via `include:
//   - state localparams IDLE=2'd0, ADD=2'd1, RESP=2'd2.
//   - default WIDTH.
//  Sub-module adder_core:
//   - WIDTH-bit ripple chain of single-bit full adders.
//   - Combinational; inputs x, y, cin; outputs sum, cout.
//  FSM, arbiter and result registers live in adder_arbiter.
// TESTING
//  1. Reset, req0 only: x=12, y=07 -> req0_ready in IDLE; 2 cycles later res_valid=1, id=0, sum=19, cout=0.
//  2. Both valid same cycle after reset: req0 {31,31}, req1 {05,03}
//     -> req0 first: sum=30, cout=1 (SAT_EN: sum=31).
//     -> then req1: id=1, sum=08.
//  3. Backpressure: hold res_ready=0 for 5 cycles in RESP
//     -> outputs stable, both readys=0, busy=1; release -> IDLE next cycle.
//  4. req1 held valid continuously, req0 idle -> three back-to-back results, id=1 each, 3 cycles apart.
//  5. Assert rst_n=0 during ADD -> outputs zero immediately; after release no stale res_valid; next grant goes to req0.
//  6. Wrap edge: {16,16} -> sum=00, cout=1 (SAT_EN: sum=31).

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: the sequencing
// states and the default operand width.
package adder_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : adder_arbiter_pkg

// File: rtl/adder_core.sv
// WIDTH-bit ripple-carry adder built from a chain of single-bit full adders.
// Purely combinational.
module adder_core
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[WIDTH];

endmodule : adder_core

// File: rtl/adder_arbiter.sv
// Shares one ripple-carry adder between two requesters. A three-state FSM
// (IDLE -> ADD -> RESP) accepts one operand pair, adds it, and holds a tagged
// result until the consumer takes it. Ties go round-robin.
// Optional feature: define ADDER_ARB_SAT_EN to saturate res_sum to all ones
// whenever the addition carries out; otherwise res_sum wraps.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    state_t           state;
    logic             rr_ptr;
    logic             op_id;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;

    // Pick a winner: the rr_ptr side wins ties, a lone requester always wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_any = req0_valid | req1_valid;
        grant_id  = rr_ptr;
        if (req0_valid && !req1_valid) begin
            grant_id = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is only offered while idle and out of reset.
    assign accept     = rst_n && (state == IDLE) && grant_any;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x    (op_x),
        .y    (op_y),
        .cin  (1'b0),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Transaction sequencer: latch operands, register the sum, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            op_id     <= 1'b0;
            op_x      <= '0;
            op_y      <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_x   <= grant_id ? req1_x : req0_x;
                        op_y   <= grant_id ? req1_y : req0_y;
                        op_id  <= grant_id;
                        rr_ptr <= ~grant_id;
                        busy   <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
`ifdef ADDER_ARB_SAT_EN
                    res_sum   <= core_cout ? '1 : core_sum;
`else
                    res_sum   <= core_sum;
`endif
                    res_cout  <= core_cout;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus a randomized
// run scored against an arithmetic/round-robin reference model.
module tb_adder_arbiter;

    localparam int W   = 5;
    localparam int LIM = 1 << W;
`ifdef ADDER_ARB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_x, req0_y;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_x, req1_y;
    logic         res_valid, res_ready, res_id, res_cout, busy;
    logic [W-1:0] res_sum;

    int checks   = 0;
    int failures = 0;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference arithmetic straight from the rules: unsigned add, cin=0.
    function automatic logic [W-1:0] exp_sum(input int x, input int y);
        int s;
        s = x + y;
        if (SAT && s >= LIM) return logic'(1'b1) ? W'(LIM - 1) : '0;
        return W'(s % LIM);
    endfunction

    function automatic logic exp_cout(input int x, input int y);
        return (x + y) >= LIM;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until res_valid or the budget runs out; reports cycles waited.
    task automatic wait_res(input int max_cyc, output bit seen, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        seen = res_valid;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_res_id: got %0b expected 0", res_id); end
        checks++; if (res_sum !== '0) begin failures++; $display("FAIL reset_res_sum: got %0d expected 0", res_sum); end
        checks++; if (res_cout !== 1'b0) begin failures++; $display("FAIL reset_res_cout: got %0b expected 0", res_cout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_readys: got %b expected 00", {req0_ready, req1_ready}); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit seen; int cyc;
        apply_reset();
        req0_valid = 1'b1; req0_x = 5'd12; req0_y = 5'd7;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if ({busy, res_valid} !== 2'b10) begin failures++; $display("FAIL single_add_phase busy/valid: got %b expected 10", {busy, res_valid}); end
        wait_res(6, seen, cyc);
        checks++; if (!seen || cyc != 1) begin failures++; $display("FAIL single_latency: got seen=%0b cycles=%0d expected seen=1 cycles=1", seen, cyc); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL single_id: got %0b expected 0", res_id); end
        checks++; if (res_sum !== exp_sum(12, 7)) begin failures++; $display("FAIL single_sum: got %0d expected %0d", res_sum, exp_sum(12, 7)); end
        checks++; if (res_cout !== 1'b0) begin failures++; $display("FAIL single_cout: got %0b expected 0", res_cout); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if ({busy, res_valid} !== 2'b00) begin failures++; $display("FAIL single_release busy/valid: got %b expected 00", {busy, res_valid}); end
    endtask

    task automatic test_tie();
        bit seen; int cyc;
        apply_reset();
        req0_valid = 1'b1; req0_x = 5'd31; req0_y = 5'd31;
        req1_valid = 1'b1; req1_x = 5'd5;  req1_y = 5'd3;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL tie_first_grant: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        wait_res(6, seen, cyc);
        checks++; if (!seen || res_id !== 1'b0) begin failures++; $display("FAIL tie_first_id: got seen=%0b id=%0b expected seen=1 id=0", seen, res_id); end
        checks++; if (res_sum !== exp_sum(31, 31)) begin failures++; $display("FAIL tie_first_sum: got %0d expected %0d", res_sum, exp_sum(31, 31)); end
        checks++; if (res_cout !== 1'b1) begin failures++; $display("FAIL tie_first_cout: got %0b expected 1", res_cout); end
        res_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL tie_ready_in_handshake: got %0b expected 0", req1_ready); end
        tick();
        res_ready = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL tie_second_grant: got %b expected 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        wait_res(6, seen, cyc);
        checks++; if (!seen || res_id !== 1'b1) begin failures++; $display("FAIL tie_second_id: got seen=%0b id=%0b expected seen=1 id=1", seen, res_id); end
        checks++; if ({res_cout, res_sum} !== {exp_cout(5, 3), exp_sum(5, 3)}) begin failures++; $display("FAIL tie_second_sum: got %0d/%0b expected %0d/%0b", res_sum, res_cout, exp_sum(5, 3), exp_cout(5, 3)); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit seen; int cyc, x, y;
        x = $urandom_range(0, LIM - 1);
        y = $urandom_range(0, LIM - 1);
        req0_valid = 1'b1; req0_x = W'(x); req0_y = W'(y);
        tick();
        req0_valid = 1'b0;
        wait_res(6, seen, cyc);
        checks++; if (!seen) begin failures++; $display("FAIL bp_result_timeout: got no res_valid expected res_valid within 6 cycles"); end
        req0_valid = 1'b1; req0_x = W'($urandom); req0_y = W'($urandom);
        req1_valid = 1'b1; req1_x = W'($urandom); req1_y = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({res_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
                {res_id, res_cout, res_sum} !== {1'b0, exp_cout(x, y), exp_sum(x, y)}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: got valid=%0b busy=%0b rdy=%b id=%0b sum=%0d cout=%0b expected valid=1 busy=1 rdy=00 id=0 sum=%0d cout=%0b",
                         i, res_valid, busy, {req0_ready, req1_ready}, res_id, res_sum, res_cout, exp_sum(x, y), exp_cout(x, y));
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        idle_inputs();
        checks++; if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL bp_release valid/busy: got %b expected 00", {res_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        int xq[$], yq[$], times[$];
        int cyc, nres;
        bit acc;
        idle_inputs();
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_x = W'($urandom); req1_y = W'($urandom);
        nres = 0;
        for (cyc = 0; cyc < 30 && nres < 3; cyc++) begin
            #1;
            acc = 1'b0;
            if (res_valid) begin
                checks++;
                if (xq.size() == 0 || res_id !== 1'b1 ||
                    {res_cout, res_sum} !== {exp_cout(xq[0], yq[0]), exp_sum(xq[0], yq[0])}) begin
                    failures++;
                    $display("FAIL b2b_result %0d: got id=%0b sum=%0d cout=%0b expected a queued id=1 result", nres, res_id, res_sum, res_cout);
                end
                if (xq.size() != 0) begin void'(xq.pop_front()); void'(yq.pop_front()); end
                times.push_back(cyc);
                nres++;
                if (nres == 3) req1_valid = 1'b0;
            end
            if (req1_ready) begin
                xq.push_back(int'(req1_x));
                yq.push_back(int'(req1_y));
                acc = 1'b1;
            end
            tick();
            if (acc) begin req1_x = W'($urandom); req1_y = W'($urandom); end
        end
        checks++; if (nres != 3) begin failures++; $display("FAIL b2b_count: got %0d results expected 3", nres); end
        for (int i = 1; i < times.size(); i++) begin
            checks++; if (times[i] - times[i - 1] != 3) begin failures++; $display("FAIL b2b_spacing %0d: got %0d cycles expected 3", i, times[i] - times[i - 1]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen; int cyc;
        idle_inputs();
        req0_valid = 1'b1; req0_x = 5'd9; req0_y = 5'd4;
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_in_add: got %0b expected 1", busy); end
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({res_valid, busy, res_id, res_cout, req0_ready, req1_ready} !== 6'b0 || res_sum !== '0) begin
            failures++;
            $display("FAIL rmid_async_clear: got valid=%0b busy=%0b id=%0b sum=%0d cout=%0b rdy=%b expected all zero",
                     res_valid, busy, res_id, res_sum, res_cout, {req0_ready, req1_ready});
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL rmid_stale cycle %0d: got valid/busy=%b expected 00", i, {res_valid, busy}); end
        end
        req0_valid = 1'b1; req0_x = 5'd2; req0_y = 5'd6;
        req1_valid = 1'b1; req1_x = 5'd1; req1_y = 5'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_next_grant: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        idle_inputs();
        wait_res(6, seen, cyc);
        checks++; if (!seen || res_id !== 1'b0 || res_sum !== exp_sum(2, 6)) begin failures++; $display("FAIL rmid_result: got seen=%0b id=%0b sum=%0d expected seen=1 id=0 sum=%0d", seen, res_id, res_sum, exp_sum(2, 6)); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit seen; int cyc;
        idle_inputs();
        req1_valid = 1'b1; req1_x = 5'd16; req1_y = 5'd16;
        tick();
        req1_valid = 1'b0;
        wait_res(6, seen, cyc);
        checks++; if (!seen || res_id !== 1'b1) begin failures++; $display("FAIL wrap_id: got seen=%0b id=%0b expected seen=1 id=1", seen, res_id); end
        checks++; if (res_sum !== exp_sum(16, 16)) begin failures++; $display("FAIL wrap_sum: got %0d expected %0d", res_sum, exp_sum(16, 16)); end
        checks++; if (res_cout !== 1'b1) begin failures++; $display("FAIL wrap_cout: got %0b expected 1", res_cout); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Random traffic scored against: one transaction in flight, result two
    // cycles after accept, ties alternate, lone requester always wins.
    task automatic test_random();
        bit v[2];
        int x[2], y[2];
        bit pending, seen_res, last, win, acc;
        int ex, ey, eid, acc_cyc, side;
        apply_reset();
        v = '{default: 1'b0};
        pending = 1'b0; seen_res = 1'b0; last = 1'b1;
        ex = 0; ey = 0; eid = 0; acc_cyc = 0; side = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (!v[s] && $urandom_range(0, 1) == 1) begin
                    v[s] = 1'b1;
                    x[s] = $urandom_range(0, LIM - 1);
                    y[s] = $urandom_range(0, LIM - 1);
                end
            end
            req0_valid = v[0]; req0_x = W'(x[0]); req0_y = W'(y[0]);
            req1_valid = v[1]; req1_x = W'(x[1]); req1_y = W'(y[1]);
            res_ready  = ($urandom_range(0, 2) != 0);
            #1;
            acc = 1'b0;
            checks++; if (busy !== pending) begin failures++; $display("FAIL rnd_busy cycle %0d: got %0b expected %0b", cyc, busy, pending); end
            if (res_valid) begin
                checks++;
                if (!pending || res_id !== eid[0] ||
                    {res_cout, res_sum} !== {exp_cout(ex, ey), exp_sum(ex, ey)} ||
                    (!seen_res && cyc - acc_cyc != 2)) begin
                    failures++;
                    $display("FAIL rnd_result cycle %0d: got id=%0b sum=%0d cout=%0b lat=%0d expected pending id=%0d sum=%0d cout=%0b lat=2",
                             cyc, res_id, res_sum, res_cout, cyc - acc_cyc, eid, exp_sum(ex, ey), exp_cout(ex, ey));
                end
                seen_res = 1'b1;
            end else if (pending && cyc - acc_cyc >= 2) begin
                checks++; failures++;
                $display("FAIL rnd_result_missing cycle %0d: got res_valid=0 expected 1", cyc);
            end
            if (req0_ready || req1_ready) begin
                win = (v[0] && v[1]) ? ~last : v[1];
                checks++;
                if (pending || (req0_ready && req1_ready) || req1_ready !== win) begin
                    failures++;
                    $display("FAIL rnd_grant cycle %0d: got rdy=%b pending=%0b expected rdy for id %0d with nothing pending",
                             cyc, {req0_ready, req1_ready}, pending, win);
                end
                side = req1_ready ? 1 : 0;
                ex = x[side]; ey = y[side]; eid = side;
                last = side[0]; acc_cyc = cyc; acc = 1'b1;
                pending = 1'b1; seen_res = 1'b0;
            end else if (!pending && (v[0] || v[1])) begin
                checks++; failures++;
                $display("FAIL rnd_no_grant cycle %0d: got rdy=00 expected a grant while idle", cyc);
            end
            if (res_valid && res_ready && pending && !acc) pending = 1'b0;
            tick();
            if (acc) v[side] = 1'b0;
        end
        idle_inputs();
        res_ready = 1'b1;
        repeat (4) tick();
        res_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_arbiter
